// File: rtl/a23_out_pkg.sv
// Shared types and constants for the a23 output streamer.
package a23_out_pkg;

    localparam int          WORD_W = 32;
    localparam logic [31:0] CC_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } out_state_t;

endpackage

// File: rtl/a23_out_streamer_if.sv
// Valid/ready beat stream from the output streamer to a host sink.
interface a23_out_streamer_if #(
    parameter int IDX_W = 6
);
    import a23_out_pkg::*;

    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_hdr;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_hdr,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_hdr,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/a23_cc_counter.sv
// Saturating cycle counter: counts enabled edges, sticks at all-ones.
module a23_cc_counter
    import a23_out_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [WORD_W-1:0] count
);

    // Increment while enabled; hold once the count reaches its maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != CC_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/a23_out_streamer.sv
// a23 output streamer: counts cycles until the core terminates, snapshots
// the flattened OUT memory and drains it word by word over a valid/ready
// stream. Define A23_OUT_HEADER_EN to prepend a beat carrying the captured
// cycle count (m_hdr=1); without it m_hdr is tied low.
module a23_out_streamer
    import a23_out_pkg::*;
#(
    parameter int OUT_MEM_SIZE = 64,
    parameter int IDX_W        = $clog2(OUT_MEM_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           terminate,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0] o,
    a23_out_streamer_if.master             strm,
    output logic [WORD_W-1:0]              cc_count,
    output logic                           done
);

`ifdef A23_OUT_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_MEM_SIZE - 1);

    out_state_t        state;
    logic [WORD_W-1:0] snap [OUT_MEM_SIZE];
    logic [WORD_W-1:0] cc_live;
    logic              capture;
    logic              valid_q;
    logic [WORD_W-1:0] data_q;
    logic [IDX_W-1:0]  index_q;
    logic [IDX_W-1:0]  index_next;
    logic              hdr_q;
    logic              last_q;

    assign capture    = (state == IDLE) && terminate;
    assign index_next = index_q + 1'b1;

    a23_cc_counter u_cc (
        .clk   (clk),
        .rst   (rst),
        .en    ((state == IDLE) && !terminate),
        .count (cc_live)
    );

    // Snapshot of the output memory, frozen at the capture edge.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < OUT_MEM_SIZE; i++) begin
                snap[i] <= o[i*WORD_W +: WORD_W];
            end
        end
    end

    // Sequencer: capture, beat handshake and terminal state, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            hdr_q    <= 1'b0;
            last_q   <= 1'b0;
            cc_count <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (terminate) begin
                        state    <= STREAM;
                        valid_q  <= 1'b1;
                        cc_count <= cc_live;
                        index_q  <= '0;
                        hdr_q    <= HDR_EN;
                        // First beat comes straight from the inputs; the snapshot
                        // array is only readable from the next cycle on.
                        data_q   <= HDR_EN ? cc_live : o[WORD_W-1:0];
                        last_q   <= !HDR_EN && (LAST_IDX == '0);
                    end
                end
                STREAM: begin
                    if (strm.m_ready) begin
                        if (hdr_q) begin
                            hdr_q   <= 1'b0;
                            data_q  <= snap[0];
                            index_q <= '0;
                            last_q  <= (LAST_IDX == '0);
                        end else if (last_q) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            index_q <= index_next;
                            data_q  <= snap[index_next];
                            last_q  <= (index_next == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign strm.m_valid = valid_q;
    assign strm.m_data  = data_q;
    assign strm.m_index = index_q;
    assign strm.m_last  = last_q;
`ifdef A23_OUT_HEADER_EN
    assign strm.m_hdr   = hdr_q;
`else
    assign strm.m_hdr   = 1'b0;
`endif

endmodule

// File: tb/tb_a23_out_streamer.sv
// Testbench for a23_out_streamer: scoreboard of expected beats fed by the
// stimulus process, popped by an independent stream monitor.
module tb_a23_out_streamer;

    localparam int N  = 64;
    localparam int IW = $clog2(N);
`ifdef A23_OUT_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int NBEATS = N + (HDR ? 1 : 0);

    typedef struct packed {
        logic [31:0]   data;
        logic [IW-1:0] index;
        logic          hdr;
        logic          last;
    } beat_t;

    logic            clk;
    logic            rst;
    logic            terminate;
    logic [N*32-1:0] o;
    logic [31:0]     cc_count;
    logic            done;

    a23_out_streamer_if #(.IDX_W(IW)) sif ();

    a23_out_streamer #(.OUT_MEM_SIZE(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .terminate (terminate),
        .o         (o),
        .strm      (sif.master),
        .cc_count  (cc_count),
        .done      (done)
    );

    int    checks     = 0;
    int    failures   = 0;
    int    beats_seen = 0;
    beat_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle; a beat visible with valid&ready transfers at the next edge.
    initial begin
        beat_t cur;
        beat_t prev;
        beat_t e;
        bit    stall_prev;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                stall_prev = 1'b0;
                continue;
            end
            cur.data  = sif.m_data;
            cur.index = sif.m_index;
            cur.hdr   = sif.m_hdr;
            cur.last  = sif.m_last;
            if (stall_prev) begin
                check("stall_valid_hold", 64'(sif.m_valid), 64'd1);
                check("stall_payload_hold", 64'(cur), 64'(prev));
            end
            if (sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(cur), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", beats_seen), 64'(cur), 64'(e));
                    beats_seen++;
                end
            end
            stall_prev = sif.m_valid && !sif.m_ready;
            prev = cur;
        end
    end

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic reset_dut();
        @(negedge clk);
        sif.m_ready = 1'b0;
        terminate   = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_m_valid", 64'(sif.m_valid), 64'd0);
        check("rst_m_data", 64'(sif.m_data), 64'd0);
        check("rst_m_index", 64'(sif.m_index), 64'd0);
        check("rst_m_hdr", 64'(sif.m_hdr), 64'd0);
        check("rst_m_last", 64'(sif.m_last), 64'd0);
        check("rst_cc_count", 64'(cc_count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic drive_o(input logic [31:0] words [N]);
        for (int i = 0; i < N; i++) o[32*i +: 32] = words[i];
    endtask

    // One dump. Called on the negedge where reset was released; base is the
    // counter value at that point, idle the number of edges with terminate low.
    task automatic run(input logic [63:0] base, input int idle, input bit rnd,
                       input bit churn, input bit a5, input int abort_after,
                       input bit timing);
        logic [31:0] words [N];
        logic [31:0] junk  [N];
        logic [63:0] exp_cc;
        beat_t       b;
        int          cyc;
        for (int c = 0; c < idle; c++) begin
            @(negedge clk);
            sif.m_ready = 1'($urandom_range(0, 1));
        end
        exp_cc = base + 64'(idle);
        if (exp_cc > 64'hFFFF_FFFF) exp_cc = 64'hFFFF_FFFF;
        for (int i = 0; i < N; i++) words[i] = a5 ? (32'hA500_0000 + 32'(i)) : $urandom();
        drive_o(words);
        terminate   = 1'b1;
        sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        beats_seen  = 0;
        if (HDR) begin
            b.data = exp_cc[31:0]; b.index = '0; b.hdr = 1'b1; b.last = 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < N; i++) begin
            b.data = words[i]; b.index = IW'(i); b.hdr = 1'b0; b.last = (i == N - 1);
            exp_q.push_back(b);
        end
        cyc = 0;
        while (!done && cyc < 3000) begin
            if (abort_after >= 0 && beats_seen >= abort_after) break;
            @(negedge clk);
            cyc++;
            sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (churn) begin
                for (int i = 0; i < N; i++) junk[i] = $urandom();
                drive_o(junk);
                terminate = 1'($urandom_range(0, 1));
            end
        end
        if (abort_after >= 0) begin
            check("abort_reached", 64'(beats_seen >= abort_after), 64'd1);
            return;
        end
        check("done_seen", 64'(done), 64'd1);
        check("cc_count", 64'(cc_count), exp_cc);
        check("all_beats_drained", 64'(exp_q.size()), 64'd0);
        if (timing) check("stream_cycles", 64'(cyc), 64'(NBEATS + 1));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            terminate   = ~terminate;
            sif.m_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) junk[i] = $urandom();
            drive_o(junk);
        end
        #1;
        check("done_sticky", 64'(done), 64'd1);
        check("cc_hold", 64'(cc_count), exp_cc);
        check("valid_low_in_done", 64'(sif.m_valid), 64'd0);
    endtask

    initial begin
        rst         = 1'b0;
        terminate   = 1'b0;
        o           = '0;
        sif.m_ready = 1'b0;

        reset_dut();
        run(64'd0, 25, 1'b0, 1'b0, 1'b1, -1, 1'b1);

        reset_dut();
        run(64'd0, int'($urandom_range(3, 40)), 1'b1, 1'b1, 1'b0, -1, 1'b0);

        reset_dut();
        run(64'd0, 0, 1'b1, 1'b1, 1'b0, -1, 1'b0);

        reset_dut();
        run(64'd0, 20, 1'b0, 1'b0, 1'b0, 11, 1'b0);
        reset_dut();
        run(64'd0, 7, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        reset_dut();
        force dut.u_cc.count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.u_cc.count;
        run(64'hFFFF_FFFE, 5, 1'b0, 1'b0, 1'b0, -1, 1'b0);

        reset_dut();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a23_out_streamer.md
Name: a23_out_streamer

Overview:
- Draining end of the a23 garbled-circuit core's flattened output memory.
- Counts clock cycles from reset release until the core raises terminate, then snapshots the OUT memory and the cycle count.
- Streams the snapshot word-by-word over a valid/ready interface to a host/UART/bench sink.
- Replaces the behavioural "wait for terminate, dump o" logic with synthesizable RTL.

Parameters:
- OUT_MEM_SIZE, 64, number of 32-bit words in the flattened output bus.
- IDX_W, $clog2(OUT_MEM_SIZE), width of the word-index output.

Ports:
- clk  input  1  system clock, posedge.
- rst  input  1  asynchronous, active-high reset.
- terminate  input  1  core-finished flag from the a23 core; level, may stay high.
- o  input  OUT_MEM_SIZE*32  flattened output memory; word i = o[32*i+31:32*i].
- m_valid  output  1  stream beat valid.
- m_ready  input  1  sink accepts the beat.
- m_data  output  32  beat payload.
- m_index  output  IDX_W  word index of the beat (0 on the header beat).
- m_hdr  output  1  beat is the cycle-count header (tied 0 without the optional feature).
- m_last  output  1  final beat of the dump.
- cc_count  output  32  captured cycle count; valid once the capture has occurred.
- done  output  1  sticky; the dump has completed.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0: m_valid, m_data, m_index, m_hdr, m_last, cc_count, done. Internal counter and index are cleared.
- Reset asserted mid-stream aborts immediately. After release the block counts again from 0; no partial resume.
- States: IDLE, STREAM, DONE.
- IDLE:
  - Each posedge with terminate=0 increments the internal cycle counter by 1, saturating at 0xFFFFFFFF without wrapping.
  - First posedge with terminate=1: capture o into an OUT_MEM_SIZE x 32 register snapshot, capture cc_count = counter, idx=0, go to STREAM.
  - m_valid goes high in the cycle immediately after that edge (1-cycle latency).
  - If terminate is already high at the first edge after reset release, the capture happens at that edge with cc_count=0.
- STREAM:
  - m_valid=1. m_data = snap[idx], m_index = idx, m_last = (idx == OUT_MEM_SIZE-1).
  - Handshake: a beat transfers on a posedge with m_valid & m_ready. On transfer, idx++.
  - While m_valid & ~m_ready, m_data, m_index, m_hdr and m_last hold stable.
  - Transfer of the m_last beat: m_valid=0 next cycle, done=1, go to DONE.
  - Back-to-back transfers sustain 1 beat/cycle.
  - m_ready asserted in IDLE or DONE has no effect.
- DONE:
  - Terminal state until reset. done stays 1 and cc_count holds.
  - Further terminate toggles and changes on o are ignored.
- Snapshot isolation: o and terminate changes after the capture edge never affect streamed data.
- m_valid never depends combinationally on m_ready.

Optional Feature:
- Macro: A23_OUT_HEADER_EN.
- Defined: on capture, the first beat is a header with m_hdr=1, m_data=cc_count, m_index=0, m_last=0. It is followed by the OUT_MEM_SIZE data beats, each with m_hdr=0. Total OUT_MEM_SIZE+1 beats.
- Undefined: no header beat. m_hdr is tied 0 and there are exactly OUT_MEM_SIZE beats.

Decomposition:
- Package a23_out_pkg:
  - WORD_W=32.
  - CC_MAX=32'hFFFF_FFFF.
  - State enum type out_state_t {IDLE, STREAM, DONE}.
- Sub-module a23_cc_counter: saturating 32-bit counter with enable and async clear. Used for the cycle count; keeps the saturation logic separately testable.
- Snapshot array, index and handshake logic stay in the top.

Test Plan:
- Reset release, terminate rises after 25 cycles with o word i = 32'hA5000000+i, m_ready=1 → cc_count=25, beats 0..63 on consecutive cycles with m_data=A5000000+i, m_last only on index 63, done=1 the cycle after.
- Random m_ready (about 50%) with o changing every cycle after capture → beat sequence identical to the captured values; payload stable while stalled; no beat dropped or duplicated.
- Terminate already high at the first edge after reset release → cc_count=0, full dump follows.
- Reset asserted after beat 10 is accepted → all outputs 0 immediately (async). Second run with terminate after 7 cycles → cc_count=7, stream restarts at index 0.
- Counter forced near saturation (counter preloaded via hierarchical force to 0xFFFFFFFE, 5 more idle cycles) → cc_count=0xFFFFFFFF, no wrap.
- With A23_OUT_HEADER_EN, terminate after 25 cycles → first beat m_hdr=1, m_data=25, then 64 data beats; total 65 transfers, m_last on the 65th.
